// File: rtl/psum_norm.sv
// ---------------------------------------------------------------------------
// PsumNorm (module psum_norm)
//
// Normalises one row of signed partial sums coming off the fullchip psum read
// path. The block accumulates the L1 sum S of the row, then runs a single
// shared restoring divider over every element in turn. Each output element is
// |p_i| * 2^(bw_out-1) / S, truncated toward zero. It is saturated to
// 2^(bw_out-1)-1 and given the sign of p_i.
//
// Parameters:
//   bw_psum  width of each signed input element
//   col      elements per row
//   bw_out   width of each signed normalised output element (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (asserted when 0)
//   in_valid   in_data holds a valid row
//   in_ready   block can accept a row (only while idle)
//   in_data    col packed two's complement elements, element i at
//              [(i+1)*bw_psum-1 : i*bw_psum]
//   out_valid  out_data holds a normalised row
//   out_ready  consumer accepts out_data
//   out_data   col packed two's complement results, element i at
//              [(i+1)*bw_out-1 : i*bw_out]
//
// Optional build macro:
//   PSUM_NORM_RELU_EN  when defined, negative elements are clamped to 0 before
//                      both the sum and the division. S then only counts the
//                      positive elements, and every output is >= 0.
//
// Latency: a row captured in cycle T produces out_valid from cycle
// T+1+col+col*bw_out. Rows never overlap.
// ---------------------------------------------------------------------------
module psum_norm #(
   parameter int bw_psum = 20,
   parameter int col     = 8,
   parameter int bw_out  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [bw_psum*col-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [bw_out*col-1:0]   out_data
);

   localparam int IDX_W = (col > 1) ? $clog2(col) : 1;
   localparam int BIT_W = (bw_out > 1) ? $clog2(bw_out) : 1;
   // The sum of col magnitudes, each at most 2^(bw_psum-1), always fits here
   localparam int SUM_W = bw_psum + $clog2(col);

   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(col - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(bw_out - 1);
   localparam logic [bw_out-1:0] Q_FULL   = {1'b1, {(bw_out-1){1'b0}}};
   localparam logic [bw_out-1:0] Q_MAX    = {1'b0, {(bw_out-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE,
      SUM,
      DIV,
      OUT
   } state_t;

   state_t                    state_q;
   state_t                    state_d;

   logic [bw_psum*col-1:0]    row_q;
   logic [SUM_W-1:0]          sum_q;
   logic [IDX_W-1:0]          idx_q;
   logic [BIT_W-1:0]          bit_q;
   logic [SUM_W-1:0]          rem_q;
   logic [bw_out-1:0]         quo_q;
   logic [bw_out*col-1:0]     res_q;

   logic                      accept;
   logic                      idx_last;
   logic                      bit_last;

   logic [bw_psum-1:0]        elem_cur;
   logic                      elem_neg;
   logic [bw_psum-1:0]        mag_cur;
   logic                      res_neg;

   logic [SUM_W:0]            trial;
   logic [SUM_W:0]            sum_ext;
   logic                      q_bit;
   logic [SUM_W:0]            rem_next;
   logic [bw_out-1:0]         quo_full;
   logic [bw_out-1:0]         quo_sat;
   logic [bw_out-1:0]         elem_res;
   logic [bw_out*col-1:0]     res_with;

   assign accept   = in_valid && in_ready;
   assign idx_last = (idx_q == IDX_LAST);
   assign bit_last = (bit_q == BIT_LAST);

   // Magnitude of the element under the shared index. In ReLU builds the
   // negative elements contribute nothing and never carry a sign.
   always_comb begin
      elem_cur = row_q[idx_q*bw_psum +: bw_psum];
      elem_neg = elem_cur[bw_psum-1];
`ifdef PSUM_NORM_RELU_EN
      mag_cur  = elem_neg ? '0 : elem_cur;
      res_neg  = 1'b0;
`else
      // The most negative value negates to 2^(bw_psum-1), which is still
      // representable once the vector is read as unsigned.
      mag_cur  = elem_neg ? (~elem_cur + bw_psum'(1)) : elem_cur;
      res_neg  = elem_neg;
`endif
   end

   // One restoring-division step. The first step of each element compares
   // the bare magnitude against S, which gives the 2^(bw_out-1) weight bit.
   // Every later step doubles the remainder first, giving one fractional bit
   // each. Because |p_i| <= S, the remainder stays below S and the doubled
   // value fits in SUM_W+1 bits.
   always_comb begin
      trial    = (bit_q == '0) ? (SUM_W+1)'(mag_cur) : {rem_q, 1'b0};
      sum_ext  = {1'b0, sum_q};
      q_bit    = (trial >= sum_ext);
      rem_next = q_bit ? (trial - sum_ext) : trial;
      quo_full = {quo_q[bw_out-2:0], q_bit};
      quo_sat  = (quo_full == Q_FULL) ? Q_MAX : quo_full;
      if (sum_q == '0) begin
         // A zero row has no meaningful ratio. The divider still runs so that
         // the latency stays fixed, but every result is forced to zero.
         elem_res = '0;
      end else if (res_neg) begin
         elem_res = ~quo_sat + bw_out'(1);
      end else begin
         elem_res = quo_sat;
      end
      res_with = res_q;
      res_with[idx_q*bw_out +: bw_out] = elem_res;
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> SUM (col cycles) -> DIV (col*bw_out cycles)
   // -> OUT (until the consumer takes the row) -> IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SUM;
            end
         end
         SUM: begin
            if (idx_last) begin
               state_d = DIV;
            end
         end
         DIV: begin
            if (idx_last && bit_last) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_valid && out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake flags are registered from the next state, so they line up with
   // the state register and stay low for the whole reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= (state_d == IDLE);
         out_valid <= (state_d == OUT);
      end
   end

   // Datapath: row capture, L1 accumulation, serial division and result
   // collection. out_data only changes when a finished row is published, so
   // it holds the previous result through backpressure and after handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_q    <= '0;
         sum_q    <= '0;
         idx_q    <= '0;
         bit_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         res_q    <= '0;
         out_data <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  row_q <= in_data;
                  sum_q <= '0;
                  idx_q <= '0;
                  bit_q <= '0;
                  rem_q <= '0;
                  quo_q <= '0;
               end
            end
            SUM: begin
               sum_q <= sum_q + SUM_W'(mag_cur);
               idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
            end
            DIV: begin
               rem_q <= rem_next[SUM_W-1:0];
               quo_q <= quo_full;
               if (bit_last) begin
                  bit_q <= '0;
                  res_q <= res_with;
                  idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
                  if (idx_last) begin
                     out_data <= res_with;
                  end
               end else begin
                  bit_q <= bit_q + BIT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
